// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host receiver with line sync, clock deglitch filter and frame timeout.
module ps2_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] data,
  output logic       data_en,
  output logic       frame_err,
  output logic       busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t         state;
  logic [1:0]     clk_s, dat_s;
  logic [3:0]     flt_cnt;
  logic           fclk, fclk_d, fall, rx_bit, par;
  logic [7:0]     sreg;
  logic [2:0]     bit_cnt;
  logic [TW-1:0]  to_cnt;
  assign fall   = fclk_d & ~fclk;
  assign rx_bit = dat_s[1];
  assign busy   = state != IDLE;
  // fclk follows the synchronized clock only after FILTER_LEN agreeing samples
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      clk_s   <= 2'b11;
      dat_s   <= 2'b11;
      flt_cnt <= '0;
      fclk    <= 1'b1;
      fclk_d  <= 1'b1;
    end else begin
      clk_s  <= {clk_s[0], PS2_CLK};
      dat_s  <= {dat_s[0], PS2_DAT};
      fclk_d <= fclk;
      if (clk_s[1] == fclk) flt_cnt <= '0;
      else if (flt_cnt == 4'(FILTER_LEN - 1)) begin
        fclk    <= clk_s[1];
        flt_cnt <= '0;
      end else flt_cnt <= flt_cnt + 4'd1;
    end
  end
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state     <= IDLE;
      data      <= '0;
      data_en   <= 1'b0;
      frame_err <= 1'b0;
      sreg      <= '0;
      bit_cnt   <= '0;
      par       <= 1'b0;
      to_cnt    <= '0;
    end else begin
      data_en   <= 1'b0;
      frame_err <= 1'b0;
      to_cnt    <= (fall || state == IDLE) ? '0 :
                   (to_cnt == TW'(TIMEOUT_CYCLES)) ? to_cnt : to_cnt + 1'b1;
      if (fall) begin
        case (state)
          IDLE: if (!rx_bit) begin
            sreg    <= '0;
            bit_cnt <= '0;
            state   <= DATA;
          end
          DATA: begin
            sreg    <= {rx_bit, sreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= rx_bit;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (rx_bit && (^sreg ^ par)) begin
              data    <= sreg;
              data_en <= 1'b1;
            end else frame_err <= 1'b1;
          end
        endcase
      end else if (state != IDLE && to_cnt >= TW'(TIMEOUT_CYCLES - 1)) begin
        // abort a stalled frame exactly TIMEOUT_CYCLES after its last fall
        state     <= IDLE;
        frame_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed PS/2 frames with assertion checks on strobes, latency, timeout and reset.
module tb_ps2_rx;
  localparam int FL = 8, TO = 600, H = 100;
  logic Clock = 0, nReset = 0, PS2_CLK = 1, PS2_DAT = 1;
  logic [7:0] data;
  logic data_en, frame_err, busy;
  int errors = 0, checks = 0, cyc = 0, fall_cyc = 0;
  int en_n, err_n, en_at, err_at, both_n = 0, busy_bad = 0;

  ps2_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .Clock(Clock), .nReset(nReset), .PS2_CLK(PS2_CLK), .PS2_DAT(PS2_DAT),
    .data(data), .data_en(data_en), .frame_err(frame_err), .busy(busy)
  );

  always #10 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    en_n = 0; err_n = 0; en_at = 0; err_at = 0;
  endtask

  task automatic watch();
    if (data_en) begin
      en_n++;
      if (en_at == 0) en_at = cyc - fall_cyc;
      if (busy) busy_bad++;
    end
    if (frame_err) begin
      err_n++;
      if (err_at == 0) err_at = cyc - fall_cyc;
      if (busy) busy_bad++;
    end
    if (data_en && frame_err) both_n++;
  endtask

  task automatic ps2_bit(input logic b);
    PS2_DAT = b;
    repeat (H) begin @(negedge Clock); watch(); end
    PS2_CLK = 0;
    fall_cyc = cyc;
    repeat (H) begin @(negedge Clock); watch(); end
    PS2_CLK = 1;
  endtask

  task automatic frame(input logic [7:0] d, input logic pflip, input logic stop);
    clr();
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(~^d ^ pflip);
    ps2_bit(stop);
  endtask

  initial begin
    repeat (3) @(negedge Clock);
    chk("rst_data", data, 8'h00);
    chk("rst_en", data_en, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    nReset = 1;
    repeat (5) @(negedge Clock);

    frame(8'h16, 0, 1);
    chk("v16_data", data, 8'h16);
    chk("v16_en_n", en_n, 1);
    chk("v16_lat", en_at, FL + 3);
    chk("v16_err_n", err_n, 0);

    frame(8'hF0, 0, 1);
    chk("f0_data", data, 8'hF0);
    chk("f0_en_n", en_n, 1);
    chk("f0_busy_gap", busy, 0);
    frame(8'h1C, 0, 1);
    chk("1c_data", data, 8'h1C);
    chk("1c_en_n", en_n, 1);
    chk("1c_lat", en_at, FL + 3);

    frame(8'h1E, 1, 1);
    chk("par_err_n", err_n, 1);
    chk("par_err_lat", err_at, FL + 3);
    chk("par_en_n", en_n, 0);
    chk("par_data_held", data, 8'h1C);

    frame(8'h1E, 0, 0);
    chk("stop_err_n", err_n, 1);
    chk("stop_en_n", en_n, 0);
    chk("stop_data_held", data, 8'h1C);
    frame(8'h45, 0, 1);
    chk("45_data", data, 8'h45);
    chk("45_en_n", en_n, 1);
    chk("45_err_n", err_n, 0);

    clr();
    PS2_CLK = 0;
    repeat (FL - 1) @(negedge Clock);
    PS2_CLK = 1;
    repeat (50) begin @(negedge Clock); watch(); end
    chk("glitch_busy", busy, 0);
    chk("glitch_strobes", en_n + err_n, 0);

    clr();
    ps2_bit(1'b0);
    chk("to_busy_mid", busy, 1);
    ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b0);
    for (int i = 0; i < TO + 200 && err_at == 0; i++) begin
      @(negedge Clock);
      watch();
    end
    chk("to_lat", err_at, FL + 3 + TO);
    chk("to_err_n", err_n, 1);
    chk("to_en_n", en_n, 0);
    chk("to_busy_end", busy, 0);
    frame(8'h26, 0, 1);
    chk("26_data", data, 8'h26);
    chk("26_en_n", en_n, 1);
    chk("26_err_n", err_n, 0);

    clr();
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b1);
    nReset = 0;
    #1;
    chk("mid_rst_data", data, 8'h00);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_en", data_en, 0);
    chk("mid_rst_err", frame_err, 0);
    @(negedge Clock);
    nReset = 1;
    repeat (7) ps2_bit(1'b1);
    chk("post_rst_en_n", en_n, 0);
    chk("post_rst_err_n", err_n, 0);
    chk("post_rst_busy", busy, 0);
    frame(8'h24, 0, 1);
    chk("24_data", data, 8'h24);
    chk("24_en_n", en_n, 1);

    chk("never_both", both_n, 0);
    chk("busy_low_at_strobe", busy_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
